// File: rtl/chip8_alu_sequencer.sv
// rtl/chip8_alu_sequencer.sv - CHIP-8 arithmetic-group sequencer driving Chip8_ALU with Vx/VF writeback.
// Optional CHIP8_SHIFT_VY_EN: 8XY6/8XYE shift Vy into Vx instead of shifting Vx in place.
package chip8_alu_pkg;
    typedef enum logic [2:0] {
        ALU_f_OR     = 3'd0,
        ALU_f_AND    = 3'd1,
        ALU_f_XOR    = 3'd2,
        ALU_f_ADD    = 3'd3,
        ALU_f_MINUS  = 3'd4,
        ALU_f_RSHIFT = 3'd5,
        ALU_f_LSHIFT = 3'd6
    } ALU_f;
endpackage

module chip8_alu_sequencer
    import chip8_alu_pkg::*;
#(
    parameter int         DATA_W   = 8,
    parameter int         ALU_W    = 16,
    parameter logic [3:0] FLAG_REG = 4'hF
) (
    input  logic              cpu_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       opcode,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [3:0]        reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_we,
    output logic [3:0]        reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [ALU_W-1:0]  alu_in1,
    output logic [ALU_W-1:0]  alu_in2,
    output ALU_f              alu_sel,
    input  logic [ALU_W-1:0]  alu_out,
    input  logic              alu_carry
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_X, S_RD_Y, S_EXEC, S_WB_X, S_WB_F, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       opcode_q, opcode_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] vx_q, vx_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              flag_q, flag_d;

    logic [3:0]        x_idx, y_idx, sub_op;
    logic              is_add_imm, has_flag;
    logic [DATA_W-1:0] vy, shift_src;
    logic              flag_calc;
    logic              unused_alu_hi;

    function automatic logic op_legal(input logic [15:0] op);
        return (op[15:12] == 4'h7) ||
               ((op[15:12] == 4'h8) && ((op[3:0] <= 4'h7) || (op[3:0] == 4'hE)));
    endfunction

    function automatic logic [ALU_W-1:0] zext(input logic [DATA_W-1:0] v);
        return {{(ALU_W-DATA_W){1'b0}}, v};
    endfunction

    assign x_idx      = opcode_q[11:8];
    assign y_idx      = opcode_q[7:4];
    assign sub_op     = opcode_q[3:0];
    assign is_add_imm = (opcode_q[15:12] == 4'h7);
    assign has_flag   = !is_add_imm && ((sub_op == 4'h4) || (sub_op == 4'h5) || (sub_op == 4'h6) ||
                                        (sub_op == 4'h7) || (sub_op == 4'hE));
    // Vy arrives on reg_rdata during EXEC (read address issued in RD_Y).
    assign vy         = reg_rdata;
    assign unused_alu_hi = ^alu_out[ALU_W-1:DATA_W];

`ifdef CHIP8_SHIFT_VY_EN
    assign shift_src = vy;
`else
    assign shift_src = vx_q;
`endif

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            vx_q      <= '0;
            res_q     <= '0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            vx_q      <= vx_d;
            res_q     <= res_d;
            flag_q    <= flag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        vx_d      = vx_q;
        res_d     = res_q;
        flag_d    = flag_q;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        illegal   = 1'b0;
        reg_raddr = 4'h0;
        reg_we    = 1'b0;
        reg_waddr = 4'h0;
        reg_wdata = '0;
        alu_in1   = '0;
        alu_in2   = '0;
        alu_sel   = ALU_f_OR;
        flag_calc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opcode_d  = opcode;
                    illegal_d = !op_legal(opcode);
                    state_d   = op_legal(opcode) ? S_RD_X : S_DONE;
                end
            end
            S_RD_X: begin
                reg_raddr = x_idx;
                state_d   = S_RD_Y;
            end
            S_RD_Y: begin
                reg_raddr = y_idx;
                vx_d      = reg_rdata;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                if (is_add_imm) begin
                    alu_sel = ALU_f_ADD;
                    alu_in1 = zext(vx_q);
                    alu_in2 = zext(opcode_q[7:0]);
                end else begin
                    case (sub_op)
                        4'h0: begin alu_sel = ALU_f_OR;  alu_in2 = zext(vy); end
                        4'h1: begin alu_sel = ALU_f_OR;  alu_in1 = zext(vx_q); alu_in2 = zext(vy); end
                        4'h2: begin alu_sel = ALU_f_AND; alu_in1 = zext(vx_q); alu_in2 = zext(vy); end
                        4'h3: begin alu_sel = ALU_f_XOR; alu_in1 = zext(vx_q); alu_in2 = zext(vy); end
                        4'h4: begin
                            alu_sel   = ALU_f_ADD;
                            alu_in1   = zext(vx_q);
                            alu_in2   = zext(vy);
                            flag_calc = alu_carry;
                        end
                        // Subtract flags are "no borrow", derived here rather than from the ALU.
                        4'h5: begin
                            alu_sel   = ALU_f_MINUS;
                            alu_in1   = zext(vx_q);
                            alu_in2   = zext(vy);
                            flag_calc = (vx_q >= vy);
                        end
                        4'h7: begin
                            alu_sel   = ALU_f_MINUS;
                            alu_in1   = zext(vy);
                            alu_in2   = zext(vx_q);
                            flag_calc = (vy >= vx_q);
                        end
                        4'h6: begin
                            alu_sel   = ALU_f_RSHIFT;
                            alu_in1   = zext(shift_src);
                            alu_in2   = ALU_W'(1);
                            flag_calc = shift_src[0];
                        end
                        4'hE: begin
                            alu_sel   = ALU_f_LSHIFT;
                            alu_in1   = zext(shift_src);
                            alu_in2   = ALU_W'(1);
                            flag_calc = shift_src[DATA_W-1];
                        end
                        default: ;
                    endcase
                end
                res_d   = alu_out[DATA_W-1:0];
                flag_d  = flag_calc;
                state_d = S_WB_X;
            end
            S_WB_X: begin
                reg_we    = 1'b1;
                reg_waddr = x_idx;
                reg_wdata = res_q;
                state_d   = has_flag ? S_WB_F : S_DONE;
            end
            // Flag is written after Vx so that X==FLAG_REG ends with the flag.
            S_WB_F: begin
                reg_we    = 1'b1;
                reg_waddr = FLAG_REG;
                reg_wdata = {{(DATA_W-1){1'b0}}, flag_q};
                state_d   = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = illegal_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// tb/tb_chip8_alu_sequencer.sv - bench for chip8_alu_sequencer with register-file and ALU models.
module tb_chip8_alu_sequencer;
    import chip8_alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] opcode;
    logic        busy, done, illegal;
    logic [3:0]  reg_raddr, reg_waddr;
    logic [7:0]  reg_rdata, reg_wdata;
    logic        reg_we;
    logic [15:0] alu_in1, alu_in2, alu_out;
    ALU_f        alu_sel;
    logic        alu_carry;

    logic [7:0]  regs [16];
    logic        tb_we;
    logic [3:0]  tb_waddr;
    logic [7:0]  tb_wdata;
    logic [8:0]  sum9;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    chip8_alu_sequencer dut (
        .cpu_clk   (clk),
        .reset     (rst),
        .start     (start),
        .opcode    (opcode),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .reg_raddr (reg_raddr),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (reg_we) regs[reg_waddr] <= reg_wdata;
        else if (tb_we) regs[tb_waddr] <= tb_wdata;
        reg_rdata <= regs[reg_raddr];
    end

    // Byte-oriented ALU: ADD carry is the carry out of bit 7; MINUS reports a borrow.
    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        sum9      = {1'b0, alu_in1[7:0]} + {1'b0, alu_in2[7:0]};
        case (alu_sel)
            ALU_f_OR:     alu_out = alu_in1 | alu_in2;
            ALU_f_AND:    alu_out = alu_in1 & alu_in2;
            ALU_f_XOR:    alu_out = alu_in1 ^ alu_in2;
            ALU_f_ADD:    begin alu_out = alu_in1 + alu_in2; alu_carry = sum9[8]; end
            ALU_f_MINUS:  begin alu_out = alu_in1 - alu_in2; alu_carry = (alu_in1 < alu_in2); end
            ALU_f_RSHIFT: alu_out = alu_in1 >> alu_in2;
            ALU_f_LSHIFT: alu_out = alu_in1 << alu_in2;
            default: ;
        endcase
    end

    task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [7:0] d, input int c);
        exp_t e;
        e.addr = a; e.data = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check_reg(input string name, input logic [3:0] a, input logic [7:0] d);
        checks++;
        if (regs[a] !== d) begin
            errors++;
            $display("FAIL %s: V%0h got %02h expected %02h", name, a, regs[a], d);
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] op, input int exp_done,
                          input logic exp_ill, input bit hold_start);
        int   cyc;
        bit   finished, ok_busy, ok_alu;
        exp_t e;
        cyc = 0; finished = 0; ok_busy = 1; ok_alu = 1;
        @(negedge clk);
        start = 1'b1; opcode = op;
        @(posedge clk);
        #1 start = 1'b0;
        while (!finished && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (hold_start && cyc == 2) begin start = 1'b1; opcode = 16'h8128; end
            if (busy !== 1'b1) ok_busy = 0;
            if (cyc != 3 && (alu_sel !== ALU_f_OR || alu_in1 !== 16'h0 || alu_in2 !== 16'h0)) ok_alu = 0;
            if (reg_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s write: unexpected write V%0h=%02h in cycle %0d", name, reg_waddr, reg_wdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (reg_waddr !== e.addr || reg_wdata !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s write: got V%0h=%02h cycle %0d expected V%0h=%02h cycle %0d",
                                 name, reg_waddr, reg_wdata, cyc, e.addr, e.data, e.cyc);
                    end
                end
            end
            if (done === 1'b1) begin
                finished = 1;
                checks++;
                if (cyc != exp_done) begin
                    errors++;
                    $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_done);
                end
                checks++;
                if (illegal !== exp_ill) begin
                    errors++;
                    $display("FAIL %s illegal: got %b expected %b", name, illegal, exp_ill);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
        end
        checks++;
        if (!ok_busy) begin errors++; $display("FAIL %s busy: got 0 expected 1 while active", name); end
        checks++;
        if (!ok_alu) begin errors++; $display("FAIL %s alu_idle: got activity expected reset values outside EXEC", name); end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes: got %0d left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s idle_after: busy got %b expected 0", name, busy); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, illegal, reg_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, illegal, reg_we});
        end
        checks++;
        if ({reg_raddr, reg_waddr, reg_wdata} !== 16'h0) begin
            errors++; $display("FAIL reset_reg_bus: got %h expected 0000", {reg_raddr, reg_waddr, reg_wdata});
        end
        checks++;
        if (alu_in1 !== 16'h0 || alu_in2 !== 16'h0) begin
            errors++; $display("FAIL reset_alu_in: got %h/%h expected 0000/0000", alu_in1, alu_in2);
        end
        checks++;
        if (alu_sel !== ALU_f_OR) begin
            errors++; $display("FAIL reset_alu_sel: got %0d expected %0d", alu_sel, ALU_f_OR);
        end
    endtask

    task automatic test_add_carry;
        set_reg(4'h1, 8'hF0); set_reg(4'h2, 8'h20); set_reg(4'hF, 8'h00);
        push_exp(4'h1, 8'h10, 4); push_exp(4'hF, 8'h01, 5);
        run_op("add_carry", 16'h8124, 6, 1'b0, 0);
        check_reg("add_carry_v1", 4'h1, 8'h10);
        check_reg("add_carry_vf", 4'hF, 8'h01);
    endtask

    task automatic test_subtract;
        set_reg(4'h1, 8'h10); set_reg(4'h2, 8'h20);
        push_exp(4'h1, 8'hF0, 4); push_exp(4'hF, 8'h00, 5);
        run_op("sub_xy", 16'h8125, 6, 1'b0, 0);
        check_reg("sub_xy_v1", 4'h1, 8'hF0);
        // V1 is now F0: 20-F0 wraps to 30 with a borrow, so VF=0.
        push_exp(4'h1, 8'h30, 4); push_exp(4'hF, 8'h00, 5);
        run_op("subn_yx", 16'h8127, 6, 1'b0, 0);
        check_reg("subn_yx_v1", 4'h1, 8'h30);
        set_reg(4'h1, 8'h20); set_reg(4'h2, 8'h20);
        push_exp(4'h1, 8'h00, 4); push_exp(4'hF, 8'h01, 5);
        run_op("sub_equal", 16'h8125, 6, 1'b0, 0);
    endtask

    task automatic test_add_imm;
        set_reg(4'h3, 8'hFF); set_reg(4'hF, 8'h5A);
        push_exp(4'h3, 8'h00, 4);
        run_op("add_imm", 16'h7301, 5, 1'b0, 0);
        check_reg("add_imm_v3", 4'h3, 8'h00);
        check_reg("add_imm_vf_kept", 4'hF, 8'h5A);
    endtask

    task automatic test_flag_reg_dest;
        set_reg(4'hF, 8'h81);
        push_exp(4'hF, 8'h02, 4); push_exp(4'hF, 8'h01, 5);
        run_op("shl_vf", 16'h8FFE, 6, 1'b0, 0);
        check_reg("shl_vf_final", 4'hF, 8'h01);
    endtask

    task automatic test_shift_right;
        set_reg(4'h1, 8'h05); set_reg(4'h2, 8'h02);
`ifdef CHIP8_SHIFT_VY_EN
        push_exp(4'h1, 8'h01, 4); push_exp(4'hF, 8'h00, 5);
`else
        push_exp(4'h1, 8'h02, 4); push_exp(4'hF, 8'h01, 5);
`endif
        run_op("shr", 16'h8126, 6, 1'b0, 0);
    endtask

    task automatic test_logic_ops;
        set_reg(4'h4, 8'h3C); set_reg(4'h5, 8'h77); set_reg(4'h6, 8'hC3);
        push_exp(4'h4, 8'h00, 4);
        run_op("xor_same", 16'h8443, 5, 1'b0, 0);
        push_exp(4'h6, 8'h77, 4);
        run_op("ld_xy", 16'h8650, 5, 1'b0, 0);
        push_exp(4'h5, 8'h77, 4);
        run_op("or_xy", 16'h8561, 5, 1'b0, 0);
        set_reg(4'h6, 8'h0F);
        push_exp(4'h5, 8'h07, 4);
        run_op("and_xy", 16'h8562, 5, 1'b0, 0);
    endtask

    task automatic test_illegal;
        run_op("illegal_8xy8", 16'h8128, 1, 1'b1, 0);
        run_op("illegal_1nnn", 16'h1234, 1, 1'b1, 0);
    endtask

    task automatic test_busy_start;
        set_reg(4'h1, 8'hF0); set_reg(4'h2, 8'h20);
        push_exp(4'h1, 8'h10, 4); push_exp(4'hF, 8'h01, 5);
        run_op("start_busy", 16'h8124, 6, 1'b0, 1);
    endtask

    task automatic test_reset_mid_op;
        set_reg(4'h1, 8'h11); set_reg(4'h2, 8'h22); set_reg(4'hF, 8'h77);
        @(negedge clk);
        start = 1'b1; opcode = 16'h8124;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (alu_sel !== ALU_f_ADD) begin
            errors++; $display("FAIL rst_mid exec: alu_sel got %0d expected %0d", alu_sel, ALU_f_ADD);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || reg_we !== 1'b0) begin
            errors++; $display("FAIL rst_mid outputs: busy/we got %b%b expected 00", busy, reg_we);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_reg("rst_mid_v1", 4'h1, 8'h11);
        check_reg("rst_mid_vf", 4'hF, 8'h77);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = 16'h0;
        tb_we = 1'b0; tb_waddr = 4'h0; tb_wdata = 8'h0;
        test_reset;
        test_add_carry;
        test_subtract;
        test_add_imm;
        test_flag_reg_dest;
        test_shift_right;
        test_logic_ops;
        test_illegal;
        test_busy_start;
        test_reset_mid_op;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
